// File: rtl/nco_pkg.sv
// Shared types and helpers for the NCO phase configuration path.
// State encoding, drop counter width and word packing.
package nco_pkg;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  localparam int DROP_CNT_WIDTH = 16;

  // Generic up to 32-bit fields; caller truncates to 2*w.
  function automatic logic [63:0] pack_cfg(
    input logic [31:0] off,
    input logic [31:0] inc,
    input int unsigned w
  );
    return ({32'd0, off} << w) | {32'd0, inc};
  endfunction

endpackage

// File: rtl/nco_phase_cfg_if.sv
// AXI-Stream config channel toward the DDS compiler.
// master drives data/valid, slave drives ready.
interface nco_phase_cfg_if #(
  parameter int PHASE_WIDTH = 16
) ();

  logic [2*PHASE_WIDTH-1:0] CFG_tdata;
  logic                     CFG_tvalid;
  logic                     CFG_tready;

  modport master (
    output CFG_tdata,
    output CFG_tvalid,
    input  CFG_tready
  );

  modport slave (
    input  CFG_tdata,
    input  CFG_tvalid,
    output CFG_tready
  );

endinterface

// File: rtl/nco_inc_calc.sv
// Phase increment = base + signed correction, wrapped or clamped.
// Clamp mode is selected by NCO_CFG_SAT_EN.
module nco_inc_calc #(
  parameter int PHASE_WIDTH = 16,
  parameter int CORR_WIDTH  = 16
) (
  input  logic [PHASE_WIDTH-1:0] base_i,
  input  logic [CORR_WIDTH-1:0]  corr_i,
  output logic [PHASE_WIDTH-1:0] inc_o
);

  logic [PHASE_WIDTH:0] corr_ext;

  assign corr_ext = {{(PHASE_WIDTH+1-CORR_WIDTH){corr_i[CORR_WIDTH-1]}},
                     corr_i};

`ifdef NCO_CFG_SAT_EN
  logic [PHASE_WIDTH:0] sum;

  assign sum = {1'b0, base_i} + corr_ext;

  // Carry bit alone is ambiguous; the correction sign tells under from over.
  always_comb begin
    inc_o = sum[PHASE_WIDTH-1:0];
    if (sum[PHASE_WIDTH]) begin
      inc_o = corr_i[CORR_WIDTH-1] ? '0 : '1;
    end
  end
`else
  assign inc_o = PHASE_WIDTH'({1'b0, base_i} + corr_ext);
`endif

endmodule

// File: rtl/nco_phase_cfg.sv
// Phase config word generator for the DDS/NCO (latest update wins).
// Optional increment clamping via NCO_CFG_SAT_EN.
module nco_phase_cfg
  import nco_pkg::*;
#(
  parameter int PHASE_WIDTH = 16,
  parameter int CORR_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PHASE_WIDTH-1:0]    base_inc,
  input  logic [PHASE_WIDTH-1:0]    phase_off,
  input  logic [CORR_WIDTH-1:0]     corr,
  input  logic                      corr_vld,
  nco_phase_cfg_if.master           cfg,
  output logic                      cfg_busy,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int DW = 2 * PHASE_WIDTH;

  logic [1:0]                state_q, state_d;
  logic [DW-1:0]             tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic [PHASE_WIDTH-1:0]    inc;
  logic [DW-1:0]             word_new;
  logic [DW-1:0]             word_init;

  nco_inc_calc #(
    .PHASE_WIDTH(PHASE_WIDTH),
    .CORR_WIDTH (CORR_WIDTH)
  ) u_inc (
    .base_i(base_inc),
    .corr_i(corr),
    .inc_o (inc)
  );

  assign word_new  = DW'(pack_cfg(32'(phase_off), 32'(inc), PHASE_WIDTH));
  assign word_init = DW'(pack_cfg(32'(phase_off), 32'(base_inc), PHASE_WIDTH));

  always_comb begin
    state_d  = state_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    drop_d   = drop_q;
    unique case (state_q)
      S_INIT: begin
        tdata_d  = word_init;
        tvalid_d = 1'b1;
        state_d  = S_SEND;
      end
      S_IDLE: begin
        if (corr_vld) begin
          tdata_d  = word_new;
          tvalid_d = 1'b1;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (corr_vld) begin
          tdata_d = word_new;
          if (!cfg.CFG_tready && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
          end
        end else if (cfg.CFG_tready) begin
          tvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        tvalid_d = 1'b0;
        state_d  = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      drop_q   <= drop_d;
    end
  end

  assign cfg.CFG_tdata  = tdata_q;
  assign cfg.CFG_tvalid = tvalid_q;
  assign cfg_busy       = tvalid_q;
  assign drop_cnt       = drop_q;

endmodule

// File: doc/nco_phase_cfg.md
Name: nco_phase_cfg

Overview:
- Drives the DDS compiler's phase configuration AXI-Stream channel, the input side of the NCO whose cos/sin output feeds the demodulator.
- Combines a static carrier frequency word with a signed loop-filter correction from the Costas/PLL loop to form the phase increment, then packs it with a phase offset.
- Delivers each word with full valid/ready handshaking; latest update wins while a word is stalled.

Parameters:
- PHASE_WIDTH, 16, width of the phase increment and phase offset fields; CFG_tdata is 2*PHASE_WIDTH.
- CORR_WIDTH, 16, width of the signed loop correction input; CORR_WIDTH <= PHASE_WIDTH.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- base_inc  input  PHASE_WIDTH  unsigned carrier phase increment, quasi-static
- phase_off  input  PHASE_WIDTH  phase offset, sampled when a word is formed
- corr  input  CORR_WIDTH  signed loop correction
- corr_vld  input  1  corr update strobe
- CFG_tdata  output  2*PHASE_WIDTH  {offset[2W-1:W], increment[W-1:0]}
- CFG_tvalid  output  1  configuration word valid
- CFG_tready  input  1  DDS accepts word
- cfg_busy  output  1  a word is pending, not yet accepted
- drop_cnt  output  16  count of updates overwritten before acceptance; saturates at 0xFFFF

Behaviour:
- Reset values:
  - CFG_tdata = 0, CFG_tvalid = 0, cfg_busy = 0, drop_cnt = 0.
  - FSM enters S_INIT.
- FSM states:
  - S_INIT: exactly one cycle after reset release. Loads CFG_tdata = {phase_off, base_inc} (zero correction), asserts CFG_tvalid, goes to S_SEND.
  - S_IDLE: CFG_tvalid = 0. On corr_vld, loads the new word, asserts CFG_tvalid next cycle, goes to S_SEND. Latency from corr_vld to CFG_tvalid is 1 cycle.
  - S_SEND: CFG_tvalid = 1 and CFG_tdata stays stable while CFG_tready = 0 (AXI rule: never drop valid or change data without a handshake).
    - Handshake (tvalid & tready) with no corr_vld: next state S_IDLE, CFG_tvalid = 0.
    - Handshake with corr_vld in the same cycle: load the new word, stay in S_SEND, CFG_tvalid stays 1. Not counted as a drop.
    - corr_vld without tready: replace the pending word with the new word, drop_cnt += 1 (saturating), stay in S_SEND. This is the only exception to data stability: an unaccepted stale word is superseded, which the DDS config channel tolerates.
- Increment arithmetic:
  - corr is sign-extended to PHASE_WIDTH+1 bits; base_inc is zero-extended to PHASE_WIDTH+1 bits.
  - inc = base_inc + corr; the result is wrapped or saturated per the optional feature.
- cfg_busy = CFG_tvalid.
- Reset asserted mid-handshake: outputs clear immediately (asynchronously); after release, the S_INIT word is re-sent.
- base_inc or phase_off changing without corr_vld triggers no send. They are picked up on the next formed word.

Optional Feature:
- NCO_CFG_SAT_EN
  - Defined: the PHASE_WIDTH+1 sum is clamped to [0, 2^PHASE_WIDTH-1]. Sums below 0 give 0; sums above the top give all-ones.
  - Undefined: inc = sum[PHASE_WIDTH-1:0] (modulo wrap, matching DDS phase arithmetic).

Decomposition:
- Shared package nco_pkg holds:
  - state encoding localparams S_INIT = 2'd0, S_IDLE = 2'd1, S_SEND = 2'd2;
  - DROP_CNT_WIDTH = 16;
  - a function packing {offset, inc}.
- One natural sub-module: nco_inc_calc, purely combinational. Performs the sign extension, the add and the wrap/saturate; the FSM registers its output.

Test Plan:
- Reset release, base_inc = 0x0400, phase_off = 0, tready = 1 -> CFG_tvalid high for exactly one cycle with CFG_tdata = 0x0000_0400; then idle.
- corr = +0x0010 with corr_vld, tready = 1 -> CFG_tvalid next cycle, tdata = 0x0000_0410, accepted in the same cycle, drop_cnt = 0.
- tready = 0; three corr_vld pulses with corr = 1, 2, 3 -> tdata ends at 0x0000_0403, drop_cnt = 2; tready raised -> single handshake, back to S_IDLE.
- base_inc = 0xFFF0, corr = +0x0020 -> without macro tdata[15:0] = 0x0010; with NCO_CFG_SAT_EN, 0xFFFF. base_inc = 0x0008, corr = -0x0010 -> 0xFFF8 without macro, 0x0000 with it.
- corr_vld coincident with handshake -> CFG_tvalid stays 1, new word appears the next cycle, drop_cnt unchanged.
- rst_n pulled low while CFG_tvalid = 1 and tready = 0 -> outputs zero immediately; after release the S_INIT word is re-sent.
